mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have no parameters; all datapaths are fixed at 32 bits and register indices at 5 bits.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 ex_valid  in  1  EX stage presents an instruction; ex_ready  out  1  stage can accept one this cycle.
REQ-005 ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch  in  1 each  control bits from EX.
REQ-006 ex_alu_zero  in  1; ex_alu_res  in  32; ex_rt_data  in  32 (store data); ex_write_reg  in  5; ex_pc_branch  in  32.
REQ-007 pc_src  out  1  take branch; pc_branch  out  32  branch target.
REQ-008 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32; dmem_ack  in  1; dmem_rdata  in  32.
REQ-009 wb_valid  out  1; wb_reg_write  out  1; wb_write_reg  out  5; wb_data  out  32; misalign  out  1; mem_err  out  1.

Function
REQ-010 SHALL accept an instruction on a rising edge where ex_valid=1 and ex_ready=1, latching all ex_* inputs into the EX/MEM register.
REQ-011 ex_ready SHALL be 1 only in state IDLE.
REQ-012 States: IDLE, ACCESS, RESP; reset state IDLE.
REQ-013 IDLE: on accept of a memory op (ex_mem_read or ex_mem_write) with ex_alu_res[1:0]=0 -> ACCESS; any other accept stays IDLE.
REQ-014 ACCESS: dmem_req=1 and dmem_addr/dmem_wdata/dmem_we held stable from latched values; on dmem_ack=1 -> RESP.
REQ-015 RESP: for one cycle, wb_valid=1 and wb_data=dmem_rdata captured at ack for loads, latched alu_res for stores; next state IDLE.
REQ-016 Non-memory accept: wb_valid=1 in the following cycle with wb_data=latched alu_res; latency 1 cycle.
REQ-017 Load/store latency: dmem_req rises in the cycle after accept; wb_valid is asserted in the cycle after dmem_ack.
REQ-018 wb_reg_write SHALL equal latched ex_reg_write, gated by wb_valid; wb_write_reg SHALL equal latched ex_write_reg.
REQ-019 wb_data SHALL select read data when latched mem_to_reg=1, otherwise alu_res.
REQ-020 dmem_we=1 when latched mem_write=1; if mem_read and mem_write are both set, write SHALL take priority and no read data SHALL be returned.
REQ-021 pc_src SHALL be a one-cycle pulse in the cycle after accept, equal to latched branch AND alu_zero; pc_branch SHALL hold the latched target.
REQ-022 Misaligned memory op (alu_res[1:0]!=0): no dmem_req; misalign=1 and wb_valid=1 with wb_reg_write=0 for one cycle.
REQ-023 dmem_ack outside ACCESS SHALL be ignored.
REQ-024 wb_valid, pc_src and misalign SHALL each be single-cycle pulses per instruction.

Reset
REQ-025 While rst_n=0 at an edge: state IDLE, dmem_req=0, dmem_we=0, wb_valid=0, wb_reg_write=0, pc_src=0, misalign=0, mem_err=0, all data/address outputs 0.
REQ-026 Reset during ACCESS SHALL abandon the transaction: dmem_req=0 from the next edge, no wb_valid for that instruction.
REQ-027 ex_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN: when defined, an 8-bit counter SHALL count ACCESS cycles; if 255 cycles pass without dmem_ack, the stage SHALL drop dmem_req, pulse mem_err for one cycle, suppress wb_valid and return to IDLE.
REQ-029 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely and mem_err SHALL be tied to 0.

Verification
REQ-030 ALU op with alu_res=0x0000_1234, reg_write=1, write_reg=5 -> next cycle wb_valid=1, wb_write_reg=5, wb_data=0x0000_1234, no dmem_req.
REQ-031 Load addr 0x100, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_req high 3 cycles, ex_ready=0 throughout, wb_data=0xDEADBEEF one cycle after ack.
REQ-032 Store addr 0x104, wdata 0xCAFE0000 -> dmem_we=1, dmem_wdata=0xCAFE0000 held until ack, wb_reg_write=0.
REQ-033 Branch=1, alu_zero=1, pc_branch=0x40 -> pc_src one-cycle pulse, pc_branch=0x40; with alu_zero=0 -> pc_src=0.
REQ-034 Load addr 0x102 -> misalign pulse, no dmem_req; with MEM_TIMEOUT_EN, ack withheld 255 cycles -> mem_err pulse, no wb_valid.
REQ-035 rst_n=0 asserted mid-ACCESS -> dmem_req=0 next edge, all outputs at reset values, ex_ready=1 after release.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake, writeback/branch outputs.
// Optional ACCESS timeout enabled by defining MEM_TIMEOUT_EN.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   typedef struct packed {
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
      logic [31:0] alu_res;
   } ex_mem_t;

endpackage

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic        ex_mem_to_reg,
   input  logic        ex_reg_write,
   input  logic        ex_branch,
   input  logic        ex_alu_zero,
   input  logic [31:0] ex_alu_res,
   input  logic [31:0] ex_rt_data,
   input  logic [4:0]  ex_write_reg,
   input  logic [31:0] ex_pc_branch,
   output logic        pc_src,
   output logic [31:0] pc_branch,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_write_reg,
   output logic [31:0] wb_data,
   output logic        misalign,
   output logic        mem_err
);

   state_t  state;
   ex_mem_t em;

   logic accept;
   logic is_mem;
   logic aligned;
   logic mem_ok;
   logic mem_bad;
   logic rd_sel;

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid & ex_ready;
   assign is_mem   = ex_mem_read | ex_mem_write;
   assign aligned  = (ex_alu_res[1:0] == 2'b00);
   assign mem_ok   = is_mem & aligned;
   assign mem_bad  = is_mem & ~aligned;
   // A write wins over a read, so only pure loads return memory data.
   assign rd_sel   = em.mem_to_reg & ~em.mem_write;

`ifdef MEM_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       tmo_hit;
   assign tmo_hit = (tmo_cnt == 8'd254);
`else
   assign mem_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         em           <= '0;
         pc_src       <= 1'b0;
         pc_branch    <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_write_reg <= '0;
         wb_data      <= '0;
         misalign     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         mem_err      <= 1'b0;
         tmo_cnt      <= '0;
`endif
      end else begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         pc_src       <= 1'b0;
         misalign     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         mem_err      <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (accept) begin
                  em.mem_write  <= ex_mem_write;
                  em.mem_to_reg <= ex_mem_to_reg;
                  em.reg_write  <= ex_reg_write;
                  em.alu_res    <= ex_alu_res;
                  pc_src        <= ex_branch & ex_alu_zero;
                  pc_branch     <= ex_pc_branch;
                  wb_write_reg  <= ex_write_reg;
                  unique case (1'b1)
                     mem_ok: begin
                        state      <= ACCESS;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_write;
                        dmem_addr  <= ex_alu_res;
                        dmem_wdata <= ex_rt_data;
`ifdef MEM_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                     end
                     mem_bad: begin
                        misalign <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_data  <= ex_alu_res;
                     end
                     default: begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= ex_reg_write;
                        wb_data      <= ex_alu_res;
                     end
                  endcase
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  state        <= RESP;
                  dmem_req     <= 1'b0;
                  dmem_we      <= 1'b0;
                  wb_valid     <= 1'b1;
                  wb_reg_write <= em.reg_write;
                  wb_data      <= rd_sel ? dmem_rdata : em.alu_res;
               end
`ifdef MEM_TIMEOUT_EN
               else if (tmo_hit) begin
                  state    <= IDLE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  mem_err  <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
`endif
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
